// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Provides default geometry, an address-width helper and packed-slice indexing.
package regfile_pkg;

    localparam int DEF_WIDTH  = 32'sd32;
    localparam int DEF_DEPTH  = 32'sd32;
    localparam int DEF_NUM_RD = 32'sd2;

    // Address width for a given entry count, never narrower than one bit
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 32'sd1;
            end
        end
        return (r < 32'sd1) ? 32'sd1 : r;
    endfunction

    // Low bit of slice idx in a packed vector of w-bit fields
    function automatic int sliceLo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port of the register file: address decode, optional bypass
// from the write port and the optional output register.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = clog2(DEF_DEPTH),
    parameter int RD_REG   = 32'sd1,
    parameter int BYPASS   = 32'sd1,
    parameter int ZERO_REG = 32'sd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DEPTH*WIDTH-1:0] entries,
    input  logic                   wrLegal,
    input  logic [ADDR_W-1:0]      wrAddr,
    input  logic [WIDTH-1:0]       writeData,
    input  logic                   rdEn,
    input  logic [ADDR_W-1:0]      rdAddr,
    output logic [WIDTH-1:0]       rdData,
    output logic                   rdValid
);

    localparam int              AW1     = ADDR_W + 32'sd1;
    localparam logic [ADDR_W:0] DEPTH_V = AW1'(DEPTH);

    logic [WIDTH-1:0] readVal_s;
    logic             inRange_s;

    // Select the addressed entry; out-of-range and hardwired-zero reads return 0
    always_comb begin
        readVal_s = {WIDTH{1'b0}};
        inRange_s = ({1'b0, rdAddr} < DEPTH_V);
        if (!inRange_s) begin
            readVal_s = {WIDTH{1'b0}};
        end else if ((ZERO_REG != 32'sd0) && (rdAddr == {ADDR_W{1'b0}})) begin
            readVal_s = {WIDTH{1'b0}};
        end else begin
            readVal_s = entries[int'(rdAddr) * WIDTH +: WIDTH];
        end
    end

    if (RD_REG != 32'sd0) begin : gRegistered
        logic [WIDTH-1:0] rdData_r;
        logic             rdValid_r;
        logic             bypassHit_s;

        // wrLegal already excludes reload cycles, so reloads never forward
        always_comb begin
            bypassHit_s = (BYPASS != 32'sd0) && wrLegal && (wrAddr == rdAddr);
        end

        // Output register: data captured only on enabled reads, valid every cycle
        always_ff @(posedge clk) begin
            if (reset) begin
                rdData_r  <= {WIDTH{1'b0}};
                rdValid_r <= 1'b0;
            end else begin
                rdValid_r <= rdEn;
                if (rdEn) begin
                    rdData_r <= bypassHit_s ? writeData : readVal_s;
                end
            end
        end

        assign rdData  = rdData_r;
        assign rdValid = rdValid_r;
    end else begin : gComb
        assign rdData  = readVal_s;
        assign rdValid = rdEn;
    end

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: write decoder, entry array with per-entry
// reset values, dirty bitmap, reload command and NUM_RD read ports.
module register_file_param
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int RD_REG   = 32'sd1,
    parameter  int BYPASS   = 32'sd1,
    parameter  int ZERO_REG = 32'sd0,
    localparam int ADDR_W   = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DEPTH*WIDTH-1:0]  initData,
    input  logic                    reload,
    input  logic                    regWrite,
    input  logic [ADDR_W-1:0]       wrAddr,
    input  logic [WIDTH-1:0]        writeData,
    input  logic [NUM_RD-1:0]       rdEn,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*WIDTH-1:0] rdData,
    output logic [NUM_RD-1:0]       rdValid,
    output logic [DEPTH-1:0]        dirty
);

    localparam int              AW1     = ADDR_W + 32'sd1;
    localparam logic [ADDR_W:0] DEPTH_V = AW1'(DEPTH);

    logic [WIDTH-1:0]       entry_r [DEPTH];
    logic [WIDTH-1:0]       initVal_s [DEPTH];
    logic [DEPTH*WIDTH-1:0] entriesFlat_s;
    logic [DEPTH-1:0]       wrDec_s;
    logic [DEPTH-1:0]       dirty_r;
    logic                   wrLegal_s;

    // Write qualification and one-hot decode of the encoded write address
    always_comb begin
        wrDec_s   = {DEPTH{1'b0}};
        wrLegal_s = regWrite && !reload && ({1'b0, wrAddr} < DEPTH_V) &&
                    !((ZERO_REG != 32'sd0) && (wrAddr == {ADDR_W{1'b0}}));
        for (int i = 32'sd0; i < DEPTH; i++) begin
            wrDec_s[i] = wrLegal_s && (wrAddr == ADDR_W'(i));
        end
    end

    // Per-entry reset/reload values and the flattened array view for the read ports
    always_comb begin
        entriesFlat_s = {(DEPTH*WIDTH){1'b0}};
        for (int i = 32'sd0; i < DEPTH; i++) begin
            if ((ZERO_REG != 32'sd0) && (i == 32'sd0)) begin
                initVal_s[i] = {WIDTH{1'b0}};
            end else begin
                initVal_s[i] = initData[sliceLo(i, WIDTH) +: WIDTH];
            end
            entriesFlat_s[sliceLo(i, WIDTH) +: WIDTH] = entry_r[i];
        end
    end

    // Entry array: reset and reload restore initial values, otherwise decoded writes
    always_ff @(posedge clk) begin
        for (int i = 32'sd0; i < DEPTH; i++) begin
            if (reset || reload) begin
                entry_r[i] <= initVal_s[i];
            end else if (wrDec_s[i]) begin
                entry_r[i] <= writeData;
            end
        end
    end

    // Dirty bitmap accumulates legal writes until the next reset or reload
    always_ff @(posedge clk) begin
        if (reset || reload) begin
            dirty_r <= {DEPTH{1'b0}};
        end else begin
            dirty_r <= dirty_r | wrDec_s;
        end
    end

    assign dirty = dirty_r;

    for (genvar p = 0; p < NUM_RD; p++) begin : gPort
        regfile_read_port #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .RD_REG  (RD_REG),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) uPort (
            .clk      (clk),
            .reset    (reset),
            .entries  (entriesFlat_s),
            .wrLegal  (wrLegal_s),
            .wrAddr   (wrAddr),
            .writeData(writeData),
            .rdEn     (rdEn[p]),
            .rdAddr   (rdAddr[sliceLo(p, ADDR_W) +: ADDR_W]),
            .rdData   (rdData[sliceLo(p, WIDTH) +: WIDTH]),
            .rdValid  (rdValid[p])
        );
    end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
Parametrised register file: DEPTH entries of WIDTH bits, one encoded write port and NUM_RD independent read ports. Each entry resets to a per-entry initial value. The block adds four things: an internal write-address decoder, registered read ports with valid flags, write-to-read bypass, and a per-entry dirty bitmap with a synchronous reload-to-initial command. It is the storage core for the datapath and the cache tag/data arrays.

Parameters:
WIDTH, 32, bits per entry
DEPTH, 32, number of entries (need not be a power of 2)
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
NUM_RD, 2, number of read ports
RD_REG, 1, 1 = registered read data (1-cycle latency); 0 = combinational read
BYPASS, 1, RD_REG=1 only: a same-cycle write to the read address is forwarded to read data
ZERO_REG, 0, 1 = entry 0 is hardwired to zero and writes to it are dropped

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
initData  in  DEPTH*WIDTH  packed initial values; entry i = initData[i*WIDTH +: WIDTH]
reload  in  1  synchronous reload of every entry from initData
regWrite  in  1  write enable
wrAddr  in  ADDR_W  write address (encoded)
writeData  in  WIDTH  write data
rdEn  in  NUM_RD  per-port read enable
rdAddr  in  NUM_RD*ADDR_W  per-port read address, packed
rdData  out  NUM_RD*WIDTH  per-port read data, packed
rdValid  out  NUM_RD  per-port read-data valid
dirty  out  DEPTH  bit i = entry i written since the last reset or reload

Behaviour:
- Reset (highest priority). Entry i <= initData slice i; entry 0 <= 0 when ZERO_REG=1. rdData <= 0, rdValid <= 0, dirty <= 0. A pending read in the reset cycle is discarded.
- Write is legal when regWrite=1, wrAddr < DEPTH, not (ZERO_REG=1 and wrAddr=0), and reload=0. A legal write sets entry[wrAddr] <= writeData and dirty[wrAddr] <= 1. Every other write is silently dropped and leaves dirty unchanged.
- Reload (reset=0, reload=1). Entries <= initData as at reset, dirty <= 0. Reload beats regWrite in the same cycle. rdData/rdValid keep their normal read behaviour.
- Read with RD_REG=1, per port p:
  - Each cycle rdValid[p] <= rdEn[p].
  - When rdEn[p]=1, rdData[p] <= entry[rdAddr[p]], so data appears the cycle after rdEn.
  - When rdEn[p]=0, rdData[p] holds its value.
  - BYPASS=1 and a legal write to the same address in the same cycle: rdData[p] <= writeData. Otherwise the read returns the pre-write contents.
  - A read in a reload cycle returns the pre-reload contents.
- Read with RD_REG=0: rdData[p] = entry[rdAddr[p]] combinationally, rdValid[p] = rdEn[p]. A write becomes visible the cycle after its edge. BYPASS is ignored.
- Out-of-range read (rdAddr >= DEPTH) returns 0 with rdValid still asserted. Entry 0 always reads 0 when ZERO_REG=1.
- All read ports may address the same entry simultaneously; no arbitration, no stalls.
- dirty is a pure register output with no combinational path from inputs.

Decomposition:
- Package regfile_pkg:
  - default WIDTH/DEPTH/NUM_RD constants
  - clog2 helper function
  - packed-slice index macros/functions for initData, rdAddr, rdData
- Sub-module regfile_read_port (one generate instance per port). Inputs: entry array view, write-side signals, rdEn, rdAddr. Outputs: rdData, rdValid. It contains the bypass compare and the output register.
- Top level contains the write decoder, the entry array, the dirty bitmap and the reload/reset muxing.

Test Plan:
- Reset with initData entry i = 32'h100+i, then read ports 0/1 at addresses 5 and 31 -> cycle after rdEn: rdData0=32'h105, rdData1=32'h11F, rdValid=2'b11, dirty=0.
- Write 32'hDEADBEEF to addr 7 while port 0 reads addr 7 in the same cycle. BYPASS=1 -> rdData0=32'hDEADBEEF next cycle. BYPASS=0 -> 32'h107, then 32'hDEADBEEF on a re-read. dirty[7]=1 in both cases.
- ZERO_REG=1: write 32'hFFFF_FFFF to addr 0 -> read returns 0 and dirty[0]=0. DEPTH=24: write to addr 30 is dropped, read of addr 30 returns 0 with rdValid=1.
- Write addrs 3 and 9, then pulse reload with regWrite=1 to addr 4 in the same cycle -> entries 3/4/9 read initData values, dirty=0.
- Hold rdEn=0 for 3 cycles after a read of 32'h105 -> rdData stays 32'h105, rdValid=0. Assert reset during an active read -> next cycle rdData=0, rdValid=0.
- RD_REG=0: write 32'hA5A5 to addr 2 -> combinational read of addr 2 shows the old value before the edge and 32'hA5A5 after it, with rdValid tracking rdEn with no delay.
